// File: rtl/reg_file_sb.sv
// Register file with busy scoreboard, optional write bypass
// and a sequential scrub engine that clears every register.
module reg_file_sb #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] Bus_In,
  input  logic             Claim,
  input  logic [AW-1:0]    Claim_Reg,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [WIDTH-1:0] SR2_Out,
  output logic             SR1_Rdy,
  output logic             SR2_Rdy,
  output logic [NREGS-1:0] Busy_Vec,
  input  logic             Scrub,
  output logic             Scrub_Busy,
  output logic             Scrub_Done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             idle;

  logic [AW-1:0]    sr   [2];
  logic [WIDTH-1:0] rout [2];
  logic             rrdy [2];

  assign idle = (state_q == IDLE);

  // Scrub sequencer: walk idx over every register once, then pulse done
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (Scrub) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx_q == LAST) state_d = DONE;
        else               idx_d   = idx_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register/busy update; scrub owns the array, else write then claim
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (state_q == CLEAR) begin
        if (idx_q == AW'(i)) begin
          mem_d[i]  = '0;
          busy_d[i] = 1'b0;
        end
      end else if (idle) begin
        if (Load && DR == AW'(i)) begin
          mem_d[i]  = Bus_In;
          busy_d[i] = 1'b0;
        end
        if (Claim && Claim_Reg == AW'(i))
          busy_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= '0;
      busy_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= mem_d[i];
      busy_q  <= busy_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign sr[0] = SR1;
  assign sr[1] = SR2;

  // Combinational read ports with same-cycle forwarding when idle
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rout[p] = '0;
      rrdy[p] = 1'b0;
      if (int'(sr[p]) < NREGS) begin
        if (BYPASS != 0 && idle && Load && DR == sr[p]) begin
          rout[p] = Bus_In;
          rrdy[p] = 1'b1;
        end else begin
          rout[p] = mem_q[sr[p]];
          rrdy[p] = ~busy_q[sr[p]];
        end
      end
    end
  end

  assign SR1_Out    = rout[0];
  assign SR2_Out    = rout[1];
  assign SR1_Rdy    = rrdy[0];
  assign SR2_Rdy    = rrdy[1];
  assign Busy_Vec   = busy_q;
  assign Scrub_Busy = !idle;
  assign Scrub_Done = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (8 regs bypass, 6 regs
// no bypass) share stimulus and are checked against a model.
module tb_reg_file_sb;

  logic        Clk;
  logic        Reset_n;
  logic        Load;
  logic [2:0]  DR;
  logic [15:0] Bus_In;
  logic        Claim;
  logic [2:0]  Claim_Reg;
  logic [2:0]  SR1, SR2;
  logic        Scrub;

  logic [15:0] a_o1, a_o2, b_o1, b_o2;
  logic        a_r1, a_r2, b_r1, b_r2;
  logic [7:0]  a_bv;
  logic [5:0]  b_bv;
  logic        a_sb, a_sd, b_sb, b_sd;

  reg_file_sb #(.WIDTH(16), .NREGS(8), .BYPASS(1)) u_a (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .DR(DR),
    .Bus_In(Bus_In), .Claim(Claim), .Claim_Reg(Claim_Reg),
    .SR1(SR1), .SR2(SR2), .SR1_Out(a_o1), .SR2_Out(a_o2),
    .SR1_Rdy(a_r1), .SR2_Rdy(a_r2), .Busy_Vec(a_bv),
    .Scrub(Scrub), .Scrub_Busy(a_sb), .Scrub_Done(a_sd)
  );

  reg_file_sb #(.WIDTH(16), .NREGS(6), .BYPASS(0)) u_b (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .DR(DR),
    .Bus_In(Bus_In), .Claim(Claim), .Claim_Reg(Claim_Reg),
    .SR1(SR1), .SR2(SR2), .SR1_Out(b_o1), .SR2_Out(b_o2),
    .SR1_Rdy(b_r1), .SR2_Rdy(b_r2), .Busy_Vec(b_bv),
    .Scrub(Scrub), .Scrub_Busy(b_sb), .Scrub_Done(b_sd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // model: contents, busy flags, scrub position
  // pos = -1 idle, 0..N-1 clearing that register, N = done cycle
  int unsigned mem [2][8];
  bit          bsy [2][8];
  int          pos [2];
  int          NR  [2] = '{8, 6};
  int          BP  [2] = '{1, 0};

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        mem[k][i] = 0;
        bsy[k][i] = 0;
      end
      pos[k] = -1;
    end
  endfunction

  function automatic void step_model();
    for (int k = 0; k < 2; k++) begin
      if (pos[k] == -1) begin
        if (Load && int'(DR) < NR[k]) begin
          mem[k][DR] = Bus_In;
          bsy[k][DR] = 0;
        end
        if (Claim && int'(Claim_Reg) < NR[k])
          bsy[k][Claim_Reg] = 1;
        if (Scrub) pos[k] = 0;
      end else if (pos[k] < NR[k]) begin
        mem[k][pos[k]] = 0;
        bsy[k][pos[k]] = 0;
        pos[k]++;
      end else begin
        pos[k] = -1;
      end
    end
  endfunction

  function automatic void exp_rd(int k, logic [2:0] s,
                                 output int unsigned o, output bit r);
    o = 0;
    r = 0;
    if (int'(s) < NR[k]) begin
      if (BP[k] == 1 && pos[k] == -1 && Load && DR == s) begin
        o = Bus_In;
        r = 1;
      end else begin
        o = mem[k][s];
        r = !bsy[k][s];
      end
    end
  endfunction

  task automatic check_all();
    int unsigned o1, o2, bv;
    bit r1, r2;
    for (int k = 0; k < 2; k++) begin
      exp_rd(k, SR1, o1, r1);
      exp_rd(k, SR2, o2, r2);
      bv = 0;
      for (int i = 0; i < NR[k]; i++)
        if (bsy[k][i]) bv |= (32'd1 << i);
      chk("sr1_out", k, k == 0 ? a_o1 : b_o1, o1);
      chk("sr2_out", k, k == 0 ? a_o2 : b_o2, o2);
      chk("sr1_rdy", k, k == 0 ? a_r1 : b_r1, r1);
      chk("sr2_rdy", k, k == 0 ? a_r2 : b_r2, r2);
      chk("busy_vec", k, k == 0 ? 32'(a_bv) : 32'(b_bv), bv);
      chk("scrub_busy", k, k == 0 ? a_sb : b_sb, pos[k] != -1);
      chk("scrub_done", k, k == 0 ? a_sd : b_sd, pos[k] == NR[k]);
    end
  endtask

  // every cycle: compare both instances against the model
  always @(negedge Clk)
    if (chk_en) check_all();

  task automatic cyc();
    @(posedge Clk);
    if (Reset_n) step_model();
    #1;
  endtask

  task automatic idle_in();
    Load = 0; DR = 0; Bus_In = 0; Claim = 0;
    Claim_Reg = 0; Scrub = 0;
  endtask

  initial begin
    int n;
    Reset_n = 0;
    idle_in();
    SR1 = 0; SR2 = 1;
    model_reset();
    repeat (2) cyc();
    chk("rst_out", 0, a_o1, 0);
    chk("rst_rdy", 0, a_r1, 1);
    chk("rst_bv", 0, a_bv, 0);
    chk("rst_sb", 0, a_sb, 0);
    Reset_n = 1;
    chk_en = 1;
    cyc();

    // write then read back
    Load = 1; DR = 3; Bus_In = 16'hBEEF;
    cyc();
    Load = 0; SR1 = 3;
    #1;
    chk("t1_out", 0, a_o1, 16'hBEEF);
    chk("t1_rdy", 0, a_r1, 1);

    // same-cycle bypass vs none
    Load = 1; DR = 5; Bus_In = 16'h1234; SR2 = 5;
    #1;
    chk("t2_byp", 0, a_o2, 16'h1234);
    chk("t2_nobyp", 1, b_o2, 16'h0000);
    cyc();
    Load = 0;

    // claim, release by write, write+claim
    Claim = 1; Claim_Reg = 2;
    cyc();
    Claim = 0; SR1 = 2;
    #1;
    chk("t3_bv2", 0, a_bv[2], 1);
    chk("t3_rdy0", 0, a_r1, 0);
    Load = 1; DR = 2; Bus_In = 16'h00AA;
    cyc();
    Load = 0;
    #1;
    chk("t3_rdy1", 0, a_r1, 1);
    chk("t3_outAA", 0, a_o1, 16'h00AA);
    Load = 1; DR = 2; Bus_In = 16'h00BB;
    Claim = 1; Claim_Reg = 2;
    cyc();
    idle_in();
    #1;
    chk("t3_lc_bv", 0, a_bv[2], 1);
    chk("t3_lc_out", 0, a_o1, 16'h00BB);

    // fill, claim, scrub
    for (int i = 0; i < 8; i++) begin
      Load = 1; DR = 3'(i); Bus_In = 16'(16'h1100 + i + 1);
      cyc();
    end
    Load = 0; Claim = 1; Claim_Reg = 1;
    cyc();
    Claim = 0; Scrub = 1;
    cyc();
    Scrub = 0;
    n = 1;
    #1;
    chk("t4_sb", 0, a_sb, 1);
    Load = 1; DR = 4; Bus_In = 16'h5555;
    cyc();
    n++;
    Load = 0;
    while (!a_sd && n < 20) begin
      cyc();
      n++;
    end
    chk("t4_lat", 0, n, 9);
    SR1 = 4; SR2 = 1;
    #1;
    chk("t4_r4", 0, a_o1, 0);
    chk("t4_bv", 0, a_bv, 0);
    cyc();

    // out-of-range on 6-register instance
    SR1 = 7;
    #1;
    chk("t5_out", 1, b_o1, 0);
    chk("t5_rdy", 1, b_r1, 0);
    Load = 1; DR = 6; Bus_In = 16'hFFFF;
    cyc();
    Load = 0; SR1 = 6;
    #1;
    chk("t5_b6", 1, b_o1, 0);
    chk("t5_a6", 0, a_o1, 16'hFFFF);
    cyc();

    // async reset during scrub
    Load = 1; DR = 0; Bus_In = 16'h7777;
    cyc();
    Load = 0; Scrub = 1; SR1 = 0;
    cyc();
    Scrub = 0;
    repeat (3) cyc();
    #2;
    Reset_n = 0;
    model_reset();
    #1;
    chk("t6_sb", 0, a_sb, 0);
    chk("t6_sd", 0, a_sd, 0);
    chk("t6_bv", 0, a_bv, 0);
    chk("t6_out", 0, a_o1, 0);
    cyc();
    Reset_n = 1;
    cyc();
    Scrub = 1;
    cyc();
    Scrub = 0;
    n = 1;
    while (!a_sd && n < 20) begin
      cyc();
      n++;
    end
    chk("t6_lat", 0, n, 9);
    cyc();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      Load      = ($urandom_range(0, 1) == 1);
      DR        = 3'($urandom_range(0, 7));
      Bus_In    = 16'($urandom);
      Claim     = ($urandom_range(0, 2) == 0);
      Claim_Reg = 3'($urandom_range(0, 7));
      SR1       = 3'($urandom_range(0, 7));
      SR2       = 3'($urandom_range(0, 7));
      Scrub     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        Reset_n = 0;
        model_reset();
        cyc();
        Reset_n = 1;
      end
      cyc();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
